// File: rtl/divider_sched_pkg.sv
// rtl/divider_sched_pkg.sv - shared types and constants for the divider scheduler
package divider_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_MANUAL = 2'd2
  } state_t;

  localparam logic [31:0] DIV_MUTE = 32'd0;
  localparam logic [31:0] MIN_DIV  = 32'd2;

  localparam int DEF_NUM_STEPS = 8;
  localparam int DEF_IDX_W     = 3;
  localparam int DEF_DUR_W     = 32;

endpackage

// File: rtl/step_table.sv
// rtl/step_table.sv - step register file: one synchronous write port, combinational read
module step_table
  import divider_sched_pkg::*;
#(
  parameter int NUM_STEPS = DEF_NUM_STEPS,
  parameter int IDX_W     = DEF_IDX_W,
  parameter int DUR_W     = DEF_DUR_W
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdiv_i,
  input  logic [DUR_W-1:0] wdur_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdiv_o,
  output logic [DUR_W-1:0] rdur_o
);

  // Entries are deliberately not reset; software programs them before use.
  logic [31:0]      div_q [NUM_STEPS];
  logic [DUR_W-1:0] dur_q [NUM_STEPS];

  // Write the addressed entry when the strobe is high.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      div_q[waddr_i] <= wdiv_i;
      dur_q[waddr_i] <= wdur_i;
    end
  end

  assign rdiv_o = div_q[raddr_i];
  assign rdur_o = dur_q[raddr_i];

endmodule

// File: rtl/divider_scheduler.sv
// rtl/divider_scheduler.sv - step sequencer with manual preemption driving the clock divider
module divider_scheduler
  import divider_sched_pkg::*;
#(
  parameter int NUM_STEPS = DEF_NUM_STEPS,
  parameter int IDX_W     = DEF_IDX_W,
  parameter int DUR_W     = DEF_DUR_W
) (
  input  logic             inclk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             loop_i,
  input  logic             manual_req_i,
  input  logic [31:0]      manual_div_i,
  input  logic             cfg_we_i,
  input  logic [IDX_W-1:0] cfg_addr_i,
  input  logic [31:0]      cfg_div_i,
  input  logic [DUR_W-1:0] cfg_dur_i,
  output logic [31:0]      divisor_o,
  output logic             div_update_o,
  output logic             mute_o,
  output logic             busy_o,
  output logic [IDX_W-1:0] step_idx_o,
  output logic             done_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [31:0]      divisor_q, divisor_d;
  logic             upd_q, upd_d;
  logic             mute_q, mute_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DUR_W-1:0] rem_q, rem_d;

  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_div;
  logic [DUR_W-1:0] rd_dur;
  logic [DUR_W-1:0] load_rem;

  step_table #(
    .NUM_STEPS (NUM_STEPS),
    .IDX_W     (IDX_W),
    .DUR_W     (DUR_W)
  ) u_table (
    .clk_i   (inclk_i),
    .we_i    (cfg_we_i),
    .waddr_i (cfg_addr_i),
    .wdiv_i  (cfg_div_i),
    .wdur_i  (cfg_dur_i),
    .raddr_i (rd_idx),
    .rdiv_o  (rd_div),
    .rdur_o  (rd_dur)
  );

  // Only one entry is ever needed per cycle: step 0 when starting, the next step
  // (wrapping naturally at the power-of-two size) while holding, the paused step
  // when returning from manual.
  always_comb begin
    rd_idx = '0;
    if (state_q == ST_HOLD) begin
      rd_idx = idx_q + IDX_W'(1);
    end else if (state_q == ST_MANUAL) begin
      rd_idx = idx_q;
    end
  end

  // A zero duration behaves as one cycle, so the countdown starts at max(dur,1)-1.
  assign load_rem = (rd_dur == '0) ? '0 : rd_dur - DUR_W'(1);

  // Next-state and registered-output logic; stop beats manual beats start/countdown.
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    divisor_d = divisor_q;
    upd_d     = 1'b0;
    done_d    = 1'b0;
    idx_d     = idx_q;
    rem_d     = rem_q;

    if (stop_i) begin
      state_d   = ST_IDLE;
      ret_d     = ST_IDLE;
      divisor_d = DIV_MUTE;
      idx_d     = '0;
      rem_d     = '0;
      upd_d     = (divisor_q != DIV_MUTE);
    end else if (manual_req_i && (state_q != ST_MANUAL)) begin
      ret_d     = state_q;
      divisor_d = manual_div_i;
      upd_d     = 1'b1;
      state_d   = ST_MANUAL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            divisor_d = rd_div;
            idx_d     = '0;
            rem_d     = load_rem;
            upd_d     = 1'b1;
            state_d   = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (rem_q != '0) begin
            rem_d = rem_q - DUR_W'(1);
          end else if ((idx_q != LAST_IDX) || loop_i) begin
            idx_d     = idx_q + IDX_W'(1);
            divisor_d = rd_div;
            rem_d     = load_rem;
            upd_d     = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            divisor_d = DIV_MUTE;
            idx_d     = '0;
            done_d    = 1'b1;
            upd_d     = 1'b1;
          end
        end
        ST_MANUAL: begin
          if (manual_req_i) begin
            if (manual_div_i != divisor_q) begin
              divisor_d = manual_div_i;
              upd_d     = 1'b1;
            end
          end else begin
            upd_d = 1'b1;
            ret_d = ST_IDLE;
            if (ret_q == ST_HOLD) begin
              divisor_d = rd_div;
              state_d   = ST_HOLD;
            end else begin
              divisor_d = DIV_MUTE;
              state_d   = ST_IDLE;
            end
          end
        end
        default: begin
          state_d   = ST_IDLE;
          ret_d     = ST_IDLE;
          divisor_d = DIV_MUTE;
        end
      endcase
    end

    mute_d = (divisor_d < MIN_DIV);
    busy_d = (state_d == ST_HOLD) || ((state_d == ST_MANUAL) && (ret_d == ST_HOLD));
  end

  // State and output registers.
  always_ff @(posedge inclk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      ret_q     <= ST_IDLE;
      divisor_q <= DIV_MUTE;
      upd_q     <= 1'b0;
      mute_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      divisor_q <= divisor_d;
      upd_q     <= upd_d;
      mute_q    <= mute_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
    end
  end

  assign divisor_o    = divisor_q;
  assign div_update_o = upd_q;
  assign mute_o       = mute_q;
  assign busy_o       = busy_q;
  assign step_idx_o   = idx_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_divider_scheduler.sv
// tb/tb_divider_scheduler.sv - scoreboard bench for divider_scheduler
module tb_divider_scheduler;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic          manual_req = 1'b0;
  logic [31:0]   manual_div = '0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_addr = '0;
  logic [31:0]   cfg_div = '0;
  logic [DW-1:0] cfg_dur = '0;
  logic [31:0]   divisor;
  logic          div_update, mute, busy, done;
  logic [IW-1:0] step_idx;

  divider_scheduler #(.NUM_STEPS(N), .IDX_W(IW), .DUR_W(DW)) dut (
    .inclk_i      (clk),
    .reset_i      (rst),
    .start_i      (start),
    .stop_i       (stop),
    .loop_i       (loop_en),
    .manual_req_i (manual_req),
    .manual_div_i (manual_div),
    .cfg_we_i     (cfg_we),
    .cfg_addr_i   (cfg_addr),
    .cfg_div_i    (cfg_div),
    .cfg_dur_i    (cfg_dur),
    .divisor_o    (divisor),
    .div_update_o (div_update),
    .mute_o       (mute),
    .busy_o       (busy),
    .step_idx_o   (step_idx),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]   tdiv [N];
  logic [DW-1:0] tdur [N];
  int            thold[N];

  typedef struct {
    int          e;
    logic [31:0] d;
    bit          dn;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int e, input logic [31:0] d, input bit dn);
    ev_t ev;
    ev.e = e; ev.d = d; ev.dn = dn;
    exp_q.push_back(ev);
  endtask

  // Every divisor load must match the next expected event in edge, value, mute and done.
  always @(negedge clk) begin
    if (!rst) begin
      if (div_update) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL stray_update: got divisor %0d at edge %0d, required no update", divisor, edge_cnt);
        end else begin
          mon_ev = exp_q.pop_front();
          check("upd_edge", 32'(edge_cnt), 32'(mon_ev.e));
          check("upd_div", divisor, mon_ev.d);
          check("upd_mute", 32'(mute), 32'(mon_ev.d < 32'd2));
          check("upd_done", 32'(done), 32'(mon_ev.dn));
        end
      end else if (done) begin
        check("done_without_update", 32'(done), 32'd0);
      end
    end
  end

  task automatic write_table();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = IW'(i);
      cfg_div  = tdiv[i];
      cfg_dur  = tdur[i];
      thold[i] = (tdur[i] == '0) ? 1 : int'(tdur[i]);
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic fill_random(input int max_dur);
    for (int i = 0; i < N; i++) begin
      tdiv[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      tdur[i] = DW'($urandom_range(0, max_dur));
    end
    write_table();
  endtask

  // Schedule of a non-loop run: step i occupies max(dur,1) edges; a manual window
  // at edge p for l edges plus one restore edge pushes everything later by l+1.
  task automatic push_run(input int t0, input int p, input int l, input int k,
                          input logic [31:0] m1, input logic [31:0] m2,
                          output int cur, output int te);
    int st;
    int acc;
    bit ins;
    int e;
    logic [31:0] d;
    cur = N - 1;
    acc = t0;
    for (int i = 0; i < N; i++) begin
      if (p > 0 && acc < p && p <= acc + thold[i]) cur = i;
      acc += thold[i];
    end
    st  = t0;
    ins = 1'b0;
    for (int j = 0; j <= N; j++) begin
      e = st;
      d = (j < N) ? tdiv[j] : 32'd0;
      if (p > 0 && !ins && e >= p) begin
        push(p, m1, 1'b0);
        if (m2 != m1) push(p + k, m2, 1'b0);
        push(p + l, tdiv[cur], 1'b0);
        ins = 1'b1;
      end
      push(ins ? e + l + 1 : e, d, (j == N));
      if (j < N) st += thold[j];
    end
    te = st + ((p > 0) ? l + 1 : 0);
  endtask

  // Looping run stopped at edge ts: loads strictly before ts, then a zeroing load
  // only if the held divisor was nonzero.
  task automatic push_loop(input int t0, input int ts);
    int t;
    int i;
    logic [31:0] last;
    t = t0; i = 0; last = 32'd0;
    while (t < ts) begin
      push(t, tdiv[i], 1'b0);
      last = tdiv[i];
      t += thold[i];
      i = (i + 1) % N;
    end
    if (last != 32'd0) push(ts, 32'd0, 1'b0);
  endtask

  task automatic drive(input int st_e, input int sp_e, input int p, input int l, input int k,
                       input logic [31:0] m1, input logic [31:0] m2, input int end_e, input int cur);
    int nx;
    do begin
      @(negedge clk);
      if (p > 0 && edge_cnt == p) begin
        check("manual_busy", 32'(busy), 32'd1);
        check("manual_step_idx", 32'(step_idx), 32'(cur));
      end
      nx         = edge_cnt + 1;
      start      = (nx == st_e);
      stop       = (nx == sp_e);
      manual_req = (p > 0) && (nx >= p) && (nx < p + l);
      manual_div = (nx < p + k) ? m1 : m2;
    end while (nx <= end_e);
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_divisor"}, divisor, 32'd0);
    check({tag, "_mute"}, 32'(mute), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  task automatic run_seq(input string tag, input int p_rel, input int l, input int k,
                         input logic [31:0] m1, input logic [31:0] m2);
    int t0, p, cur, te;
    @(negedge clk);
    t0 = edge_cnt + 2;
    p  = (p_rel > 0) ? t0 + p_rel : -1;
    push_run(t0, p, l, k, m1, m2, cur, te);
    drive(t0, -1, p, l, k, m1, m2, te + 2, cur);
    idle_checks(tag);
  endtask

  task automatic run_loop(input string tag, input int ts_rel);
    int t0;
    @(negedge clk);
    loop_en = 1'b1;
    t0 = edge_cnt + 2;
    push_loop(t0, t0 + ts_rel);
    drive(t0, t0 + ts_rel, -1, 0, 0, 32'd0, 32'd0, t0 + ts_rel + 2, 0);
    check({tag, "_step_idx"}, 32'(step_idx), 32'd0);
    idle_checks(tag);
    loop_en = 1'b0;
  endtask

  function automatic int total_hold();
    int s = 0;
    for (int i = 0; i < N; i++) s += thold[i];
    return s;
  endfunction

  initial begin
    int t0, cur, te, tot, pr, l, k;
    logic [31:0] m1, m2;

    repeat (3) @(negedge clk);
    check("rst_divisor", divisor, 32'd0);
    check("rst_update", 32'(div_update), 32'd0);
    check("rst_mute", 32'(mute), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_step_idx", 32'(step_idx), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < N; i++) begin tdiv[i] = 32'(10 + i); tdur[i] = DW'(3); end
    write_table();
    run_seq("plain", -1, 0, 0, 0, 0);

    for (int i = 0; i < N; i++) begin tdiv[i] = 32'(20 + i); tdur[i] = (i == 2) ? DW'(0) : DW'(2); end
    write_table();
    run_seq("dur0", -1, 0, 0, 0, 0);

    for (int i = 0; i < N; i++) begin tdiv[i] = 32'(10 + i); tdur[i] = DW'(1); end
    write_table();
    run_loop("loop_wrap", 20);

    for (int i = 0; i < N; i++) begin tdiv[i] = 32'(100 + i); tdur[i] = DW'(8); end
    write_table();
    run_seq("manual_step3", 27, 10, 1, 32'd500, 32'd500);

    for (int r = 0; r < 4; r++) begin
      fill_random(4);
      run_seq("rand_plain", -1, 0, 0, 0, 0);
    end

    for (int r = 0; r < 6; r++) begin
      fill_random(5);
      tot = total_hold();
      pr  = $urandom_range(1, tot);
      l   = $urandom_range(2, 8);
      k   = $urandom_range(1, l - 1);
      m1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      m2  = ($urandom_range(0, 1) == 0) ? m1 : $urandom;
      run_seq("rand_manual", pr, l, k, m1, m2);
    end

    for (int r = 0; r < 4; r++) begin
      fill_random(4);
      run_loop("rand_loop_stop", $urandom_range(1, 3 * total_hold()));
    end

    @(negedge clk);
    t0 = edge_cnt + 2;
    drive(t0, t0, -1, 0, 0, 32'd0, 32'd0, t0 + 3, 0);
    idle_checks("start_stop_idle");

    for (int i = 0; i < N; i++) begin tdiv[i] = 32'(40 + i); tdur[i] = DW'(3); end
    write_table();
    @(negedge clk);
    t0 = edge_cnt + 1;
    push_run(t0, -1, 0, 0, 0, 0, cur, te);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_divisor", divisor, 32'd0);
    check("async_rst_mute", 32'(mute), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_step_idx", 32'(step_idx), 32'd0);
    check("async_rst_update", 32'(div_update), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run_seq("after_reset", -1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/divider_scheduler.md
Name: divider_scheduler

Overview:
Sequencer/arbiter that drives the 32-bit divisor input of the team's clock_divider. It plays a programmable table of (divisor, duration) steps, one step after another. A manual requester (keyboard/switch note) preempts the sequence and is granted the divider. When the manual request releases, the paused sequence resumes where it left off. All outputs are registered; div_update tells the downstream divider that a new divisor has been applied.

Parameters:
NUM_STEPS, 8, number of table entries (power of two, ≥2)
IDX_W, 3, log2(NUM_STEPS)
DUR_W, 32, width of duration field (inclk cycles)

Ports:
inclk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level; sampled high in IDLE begins sequence at step 0
stop  in  1  level; forces IDLE from any state
loop  in  1  1 = wrap to step 0 after last step; 0 = finish
manual_req  in  1  manual requester wants the divider
manual_div  in  32  divisor requested by manual requester
cfg_we  in  1  table write strobe
cfg_addr  in  IDX_W  table write index
cfg_div  in  32  step divisor to write
cfg_dur  in  DUR_W  step duration to write
divisor  out  32  divisor to clock_divider
div_update  out  1  one-cycle pulse on every divisor load
mute  out  1  1 when divisor < 2 (divider output must be gated)
busy  out  1  1 in HOLD or MANUAL-with-sequence-paused
step_idx  out  IDX_W  current step index
done  out  1  one-cycle pulse when non-loop sequence completes

Behaviour:
- Reset (async): state IDLE, divisor=0, div_update=0, mute=1, busy=0, step_idx=0, done=0, remaining=0, ret_state=IDLE. Table contents are not reset (X until written).
- States: IDLE, HOLD, MANUAL. ret_state ∈ {IDLE, HOLD} records the state that MANUAL returns to.
- Priority at each edge: reset > stop > manual_req > start / countdown.
- IDLE, start=1: next edge loads divisor=table[0].div, step_idx=0, remaining=max(dur,1)-1. State goes to HOLD, div_update=1.
- HOLD, remaining>0: decrement. When remaining==0 at an edge, advance in that same edge:
  - idx<NUM_STEPS-1: idx+1, load table[idx+1], pulse div_update.
  - idx==last and loop=1: idx=0, load table[0], pulse div_update.
  - idx==last and loop=0: go to IDLE, divisor=0, done=1 for one cycle, div_update=1.
- Each step's divisor is therefore held exactly max(dur,1) cycles. A duration of 0 behaves as 1.
- Manual preemption: manual_req=1 while not in MANUAL causes the following at the next edge:
  - ret_state ← current state, divisor ← manual_div, div_update=1, state MANUAL.
  - remaining and step_idx are frozen.
- In MANUAL, a change of manual_div updates divisor at the next edge with a div_update pulse. No pulse is issued if the value is unchanged.
- manual_req=0 in MANUAL:
  - ret_state=HOLD: restore divisor=table[step_idx].div, pulse div_update, resume countdown from the frozen remaining value. The restore cycle does not decrement.
  - ret_state=IDLE: divisor=0, pulse div_update.
- stop=1: next edge goes to IDLE, divisor=0, ret_state=IDLE, step_idx=0, div_update=1 only if divisor was nonzero, done=0.
  - If manual_req is still high, MANUAL is re-entered on the following edge with ret_state=IDLE.
- start while busy is ignored. start and stop in the same cycle: stop wins.
- Config writes are accepted in any state and take effect the next time that entry is loaded. A write to the current step does not alter the held divisor.
- mute = (divisor < 2), registered alongside divisor.
- busy = (state==HOLD) or (state==MANUAL and ret_state==HOLD).

Decomposition:
- Package divider_sched_pkg: state enum (IDLE, HOLD, MANUAL), DIV_MUTE=32'd0, MIN_DIV=32'd2, default widths.
- Sub-module step_table: NUM_STEPS × {32-bit div, DUR_W-bit dur} register file, one synchronous write port, combinational read by index.

Test Plan:
- Load steps 0..7 with div=10+i, dur=3, loop=0; pulse start → divisor 10,11,…,17, each held 3 cycles. 8 div_update pulses, then divisor=0, done=1 for one cycle, mute=1.
- Step 2 dur=0, others dur=2 → step 2 divisor present exactly 1 cycle.
- loop=1, dur=1 → step_idx wraps 7→0 with no gap. done never pulses.
- Sequence in step 3 with remaining=5; manual_req=1 with manual_div=500 for 10 cycles → divisor=500, step_idx stays 3. Release → divisor=table[3].div and 6 more cycles in step 3 (1 restore + 5).
- stop and start asserted together in IDLE → stays IDLE. stop during HOLD → IDLE next edge, divisor=0, busy=0.
- Assert reset mid-HOLD (asynchronously, between edges) → outputs immediately at reset values. Table retains the written entries.
